regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Configurable width, depth and read-port count.
- Registered reads with write-through bypass, byte-enabled writes, hardwired-zero register 0, and a busy-bit scoreboard for the datapath pipeline.
- After reset, a clear sequencer sweeps zeros into storage before the block reports READY, so storage can map to flop arrays or SRAM macros without a global clear.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy.
- AW, log2(DEPTH), address width (derived).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- READY  out  1  high once the clear sweep is done; reset value 0.
- READ  in  1  read strobe, applies to all read ports.
- ADDR_R  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- DATA_R  out  NUM_RD*DATA_WIDTH  packed read data; reset value 0.
- BUSY_R  out  NUM_RD  busy bit of each addressed register, registered with DATA_R; reset value 0.
- WRITE  in  1  write strobe.
- ADDR_W  in  AW  write address.
- DATA_W  in  DATA_WIDTH  write data.
- BE_W  in  DATA_WIDTH/8  byte enables; BE_W[i] covers bits [8i+7:8i].
- RSV  in  1  reserve strobe: mark the register at ADDR_RSV busy.
- ADDR_RSV  in  AW  address to reserve.
- RSV_ERR  out  1  one-cycle pulse when a reserve targets an already-busy register; reset value 0.

Behaviour:
- Reset
  - RST sampled high at an edge forces state CLEAR with sweep counter 0.
  - Outputs go to READY=0, DATA_R=0, BUSY_R=0, RSV_ERR=0.
  - All busy bits clear in the same edge.
  - RST asserted mid-sweep or mid-operation restarts the sweep from 0.
- State machine (two states: CLEAR, RUN)
  - CLEAR: write 0 to register[cnt] each cycle; cnt increments.
  - When cnt = DEPTH-1, the next state is RUN and READY rises on that edge. The sweep therefore takes DEPTH cycles after RST deasserts.
  - In CLEAR, READ/WRITE/RSV are ignored: DATA_R holds 0 and RSV_ERR stays 0.
  - RUN: normal operation; leaves RUN only via RST.
- Read
  - Latency is 1 cycle.
  - If READ is high at edge N, DATA_R/BUSY_R show the port contents after edge N.
  - If READ is low, DATA_R and BUSY_R hold their previous values.
- Bypass
  - Applies when WRITE and READ fall in the same cycle and ADDR_R[k] == ADDR_W.
  - Port k returns the merged value: enabled bytes from DATA_W, other bytes from the old contents.
  - Ports may alias the same address; each port returns the identical value.
- Write
  - On an edge with WRITE high, the bytes selected by BE_W update. BE_W=0 leaves data unchanged.
  - A write to ADDR_W clears that register's busy bit, even when BE_W=0.
- Zero register (ZERO_REG=1)
  - Writes to address 0 are dropped, and address 0 always reads 0 with busy 0.
  - RSV to address 0 is ignored and never raises RSV_ERR.
- Scoreboard
  - RSV sets busy[ADDR_RSV] at the edge.
  - If that register is already busy and is not being written in the same cycle, RSV_ERR pulses the next cycle; busy stays 1.
  - RSV and WRITE to the same address in the same cycle: busy ends at 1 (the new producer wins) and no error.
  - BUSY_R reflects pre-edge busy state, except that a same-cycle WRITE to that address shows busy 0 and a same-cycle RSV shows busy 1. This matches the bypass rule.
- Width rules
  - Addresses are AW bits, so DEPTH being a power of two means no out-of-range addresses exist.
  - The sweep counter is AW bits and is compared against DEPTH-1.

Decomposition:
- Shared package `regfile_pkg`: state encoding (CLEAR=0, RUN=1), clog2 helper, and the byte-merge function used by both the write path and the bypass.
- One sub-module, `regfile_scoreboard`: the DEPTH busy bits, RSV/WRITE update, RSV_ERR and the per-port busy lookup.
- Storage, the sweep FSM and the read ports stay in the top module.

Test Plan:
1. Reset sweep: RST high 2 cycles then low → READY=0 for exactly 32 cycles, then 1; a READ of every address returns 00000000. Re-assert RST at sweep cycle 10 → READY stays 0 for a full 32 more cycles.
2. Write/read all: write DATA_W=i with BE_W=F to addresses 1..31, then READ with ADDR_R0=i, ADDR_R1=31-i → DATA_R0=i and DATA_R1=31-i one cycle later. Address 0 returns 0 after a write of FFFFFFFF.
3. Byte enables + bypass: reg5=11223344. In the same cycle, WRITE addr5 DATA_W=AABBCCDD BE_W=0101 and READ both ports addr5 → both return 11BB33DD; a later read also returns 11BB33DD.
4. Scoreboard: RSV addr7 → BUSY_R=1 on the next read. A second RSV addr7 → RSV_ERR pulses exactly 1 cycle. WRITE addr7 → BUSY_R=0. RSV+WRITE addr7 in the same cycle → BUSY_R=1 and RSV_ERR=0.
5. Param variant DATA_WIDTH=64, DEPTH=16, NUM_RD=3, ZERO_REG=0: sweep takes 16 cycles; address 0 is writable (holds 0123456789ABCDEF); all three ports read independently.
6. Ignore-during-CLEAR: WRITE addr3=DEADBEEF and RSV addr3 during the sweep → after READY, addr3 reads 00000000, busy 0, and RSV_ERR never asserted.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared types and helpers for the multi-port register file.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Widest register the byte-merge helper supports; callers cast down.
    localparam int c_MAX_DW = 256;
    localparam int c_MAX_BE = c_MAX_DW / 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [c_MAX_DW-1:0] byte_merge(
        input logic [c_MAX_DW-1:0] old_v,
        input logic [c_MAX_DW-1:0] new_v,
        input logic [c_MAX_BE-1:0] be
    );
        logic [c_MAX_DW-1:0] r;
        for (int i = 0; i < c_MAX_BE; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Busy-bit tracking, reserve-error pulse and per-port busy lookup.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_write,
    input  logic [AW-1:0]        i_addr_w,
    input  logic                 i_rsv,
    input  logic [AW-1:0]        i_addr_rsv,
    input  logic [NUM_RD*AW-1:0] i_addr_r,
    output logic [NUM_RD-1:0]    o_busy,
    output logic                 o_err
);

    logic [DEPTH-1:0] r_busy;
    logic             r_err;
    logic             w_wr;
    logic             w_rsv;

    assign w_wr  = i_en && i_write;
    assign w_rsv = i_en && i_rsv && !((ZERO_REG != 0) && (i_addr_rsv == '0));

    // Reserve is applied after the write-clear so a new producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_rsv && r_busy[i_addr_rsv] && !(w_wr && (i_addr_w == i_addr_rsv));
            if (w_wr)  r_busy[i_addr_w]   <= 1'b0;
            if (w_rsv) r_busy[i_addr_rsv] <= 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_lu
            logic [AW-1:0] w_addr;
            assign w_addr = i_addr_r[k*AW +: AW];
            always_comb begin
                o_busy[k] = r_busy[w_addr];
                if (w_wr && (w_addr == i_addr_w))    o_busy[k] = 1'b0;
                if (w_rsv && (w_addr == i_addr_rsv)) o_busy[k] = 1'b1;
            end
        end
    endgenerate

    assign o_err = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Brief    : Parametrised multi-read register file with bypass, byte enables,
//            post-reset clear sweep and busy-bit scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         o_ready,
    input  logic                         i_read,
    input  logic [NUM_RD*AW-1:0]         i_addr_r,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_data_r,
    output logic [NUM_RD-1:0]            o_busy_r,
    input  logic                         i_write,
    input  logic [AW-1:0]                i_addr_w,
    input  logic [DATA_WIDTH-1:0]        i_data_w,
    input  logic [DATA_WIDTH/8-1:0]      i_be_w,
    input  logic                         i_rsv,
    input  logic [AW-1:0]                i_addr_rsv,
    output logic                         o_rsv_err
);

    state_t                r_state;
    logic [AW-1:0]         r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NUM_RD-1:0]     w_busy_lu;

    assign w_run   = (r_state == ST_RUN);
    assign w_wr_en = w_run && i_write && !((ZERO_REG != 0) && (i_addr_w == '0));

    // Shared by the storage write and the same-cycle read bypass.
    assign w_wr_data = DATA_WIDTH'(byte_merge(c_MAX_DW'(r_mem[i_addr_w]),
                                              c_MAX_DW'(i_data_w),
                                              c_MAX_BE'(i_be_w)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == AW'(DEPTH - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // No reset on storage: the sweep zeroes it so it can map to a macro.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[i_addr_w] <= w_wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_run),
        .i_write    (i_write),
        .i_addr_w   (i_addr_w),
        .i_rsv      (i_rsv),
        .i_addr_rsv (i_addr_rsv),
        .i_addr_r   (i_addr_r),
        .o_busy     (w_busy_lu),
        .o_err      (o_rsv_err)
    );

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]         w_addr;
            logic [DATA_WIDTH-1:0] w_val;
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_busy;

            assign w_addr = i_addr_r[k*AW +: AW];

            always_comb begin
                w_val = r_mem[w_addr];
                if (w_wr_en && (w_addr == i_addr_w)) w_val = w_wr_data;
                if ((ZERO_REG != 0) && (w_addr == '0)) w_val = '0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                    r_busy <= 1'b0;
                end else if (w_run && i_read) begin
                    r_data <= w_val;
                    r_busy <= w_busy_lu[k];
                end
            end

            assign o_data_r[k*DATA_WIDTH +: DATA_WIDTH] = r_data;
            assign o_busy_r[k]                          = r_busy;
        end
    endgenerate

    assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Brief    : Scoreboard bench for regfile_mp_sb (default and 64x16x3 variant).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Default instance: 32-bit, 32 deep, 2 ports, zero register
    logic        ready, read, write, rsv, rsv_err;
    logic [9:0]  addr_r;
    logic [63:0] data_r;
    logic [1:0]  busy_r;
    logic [4:0]  addr_w, addr_rsv;
    logic [31:0] data_w;
    logic [3:0]  be_w;

    // Variant: 64-bit, 16 deep, 3 ports, register 0 writable
    logic         v_ready, v_read, v_write, v_rsv, v_rsv_err;
    logic [11:0]  v_addr_r;
    logic [191:0] v_data_r;
    logic [2:0]   v_busy_r;
    logic [3:0]   v_addr_w, v_addr_rsv;
    logic [63:0]  v_data_w;
    logic [7:0]   v_be_w;

    regfile_mp_sb u_dut (
        .clk(clk), .rst(rst), .o_ready(ready), .i_read(read), .i_addr_r(addr_r),
        .o_data_r(data_r), .o_busy_r(busy_r), .i_write(write), .i_addr_w(addr_w),
        .i_data_w(data_w), .i_be_w(be_w), .i_rsv(rsv), .i_addr_rsv(addr_rsv),
        .o_rsv_err(rsv_err)
    );

    regfile_mp_sb #(.DATA_WIDTH(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(0)) u_var (
        .clk(clk), .rst(rst), .o_ready(v_ready), .i_read(v_read), .i_addr_r(v_addr_r),
        .o_data_r(v_data_r), .o_busy_r(v_busy_r), .i_write(v_write), .i_addr_w(v_addr_w),
        .i_data_w(v_data_w), .i_be_w(v_be_w), .i_rsv(v_rsv), .i_addr_rsv(v_addr_rsv),
        .o_rsv_err(v_rsv_err)
    );

    typedef struct {
        string           name;
        logic [3:0][63:0] d;
        logic [3:0]      b;
    } rd_exp_t;

    typedef struct {
        int   cyc;
        logic v;
    } err_exp_t;

    rd_exp_t  q_a[$];
    rd_exp_t  q_b[$];
    err_exp_t q_err_a[$];
    err_exp_t q_err_b[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rd_pend_a = 1'b0;
    logic rd_pend_b = 1'b0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_pend_a <= read;
        rd_pend_b <= v_read;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a read result is presented
    always @(negedge clk) begin
        rd_exp_t  e;
        err_exp_t ee;
        if (rd_pend_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_read: got read result expected none at cycle %0d", cyc);
            end else begin
                e = q_a.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("%s.d%0d", e.name, k), 64'(data_r[k*32 +: 32]), e.d[k]);
                    chk($sformatf("%s.b%0d", e.name, k), 64'(busy_r[k]), 64'(e.b[k]));
                end
            end
        end
        if (rd_pend_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_read: got read result expected none at cycle %0d", cyc);
            end else begin
                e = q_b.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("%s.d%0d", e.name, k), v_data_r[k*64 +: 64], e.d[k]);
                    chk($sformatf("%s.b%0d", e.name, k), 64'(v_busy_r[k]), 64'(e.b[k]));
                end
            end
        end
        if (q_err_a.size() > 0 && q_err_a[0].cyc == cyc) begin
            ee = q_err_a.pop_front();
            chk($sformatf("a_rsv_err@%0d", ee.cyc), 64'(rsv_err), 64'(ee.v));
        end else if (rsv_err !== 1'b0) begin
            checks++; errors++;
            $display("FAIL a_rsv_err_unexpected: got %b expected 0 at cycle %0d", rsv_err, cyc);
        end
        if (q_err_b.size() > 0 && q_err_b[0].cyc == cyc) begin
            ee = q_err_b.pop_front();
            chk($sformatf("b_rsv_err@%0d", ee.cyc), 64'(v_rsv_err), 64'(ee.v));
        end else if (v_rsv_err !== 1'b0) begin
            checks++; errors++;
            $display("FAIL b_rsv_err_unexpected: got %b expected 0 at cycle %0d", v_rsv_err, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_exp(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                         input logic b0, input logic b1);
        rd_exp_t e;
        e.name = nm; e.d = '0; e.d[0] = 64'(d0); e.d[1] = 64'(d1); e.b = {2'b00, b1, b0};
        q_a.push_back(e);
    endtask

    task automatic a_rd(input string nm, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1);
        a_exp(nm, d0, d1, b0, b1);
        read = 1'b1; addr_r = {a1, a0};
        tick();
        read = 1'b0;
    endtask

    task automatic a_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1'b1; addr_w = a; data_w = d; be_w = be;
        tick();
        write = 1'b0;
    endtask

    task automatic a_err(input int dc, input logic v);
        err_exp_t ee;
        ee.cyc = cyc + dc; ee.v = v;
        q_err_a.push_back(ee);
    endtask

    task automatic b_rd(input string nm, input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [2:0] b);
        rd_exp_t e;
        e.name = nm; e.d = '0; e.d[0] = d0; e.d[1] = d1; e.d[2] = d2; e.b = {1'b0, b};
        q_b.push_back(e);
        v_read = 1'b1; v_addr_r = {a2, a1, a0};
        tick();
        v_read = 1'b0;
    endtask

    task automatic b_wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
        v_write = 1'b1; v_addr_w = a; v_data_w = d; v_be_w = be;
        tick();
        v_write = 1'b0;
    endtask

    // Counts edges after reset release until each READY rises; optionally
    // drives write/reserve to address 3 while the sweep is past it.
    task automatic count_sweep(input string nm, input bit poke);
        int na, nb;
        na = 0; nb = 0;
        for (int n = 1; n <= 40 && (na == 0 || nb == 0); n++) begin
            if (poke) begin
                write = (n >= 6 && n < 20); addr_w = 5'd3; data_w = 32'hDEADBEEF; be_w = 4'hF;
                rsv   = (n >= 6 && n < 20); addr_rsv = 5'd3;
            end
            tick();
            if (na == 0 && ready === 1'b1)   na = n;
            if (nb == 0 && v_ready === 1'b1) nb = n;
        end
        write = 1'b0; rsv = 1'b0;
        chk({nm, "_a_cycles"}, 64'(na), 64'd32);
        chk({nm, "_b_cycles"}, 64'(nb), 64'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        read = 0; write = 0; rsv = 0; addr_r = '0; addr_w = '0; addr_rsv = '0; data_w = '0; be_w = '0;
        v_read = 0; v_write = 0; v_rsv = 0; v_addr_r = '0; v_addr_w = '0; v_addr_rsv = '0;
        v_data_w = '0; v_be_w = '0;

        // Reset values and sweep length
        tick(); tick();
        chk("rst_ready",    64'(ready),   64'd0);
        chk("rst_data_r",   data_r,       64'd0);
        chk("rst_busy_r",   64'(busy_r),  64'd0);
        chk("rst_v_ready",  64'(v_ready), 64'd0);
        chk("rst_v_data_r", v_data_r[63:0], 64'd0);
        rst = 1'b0;
        count_sweep("sweep", 1'b0);
        for (int i = 0; i < 32; i++) a_rd("clr_all", 5'(i), 5'(31 - i), 32'd0, 32'd0, 1'b0, 1'b0);

        // Restart mid-sweep; write/reserve during CLEAR must be ignored
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (10) tick();
        chk("mid_sweep_ready", 64'(ready), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        count_sweep("sweep_restart", 1'b1);
        a_rd("clr_ignored", 5'd3, 5'd3, 32'd0, 32'd0, 1'b0, 1'b0);

        // Write/read all, register 0 hardwired
        for (int i = 1; i < 32; i++) a_wr(5'(i), 32'(i), 4'hF);
        a_wr(5'd0, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 32; i++) a_rd("rd_all", 5'(i), 5'(31 - i), 32'(i), 32'(31 - i), 1'b0, 1'b0);

        // Byte-enabled write with same-cycle bypass on aliased ports
        a_wr(5'd5, 32'h11223344, 4'hF);
        write = 1'b1; addr_w = 5'd5; data_w = 32'hAABBCCDD; be_w = 4'b0101;
        read = 1'b1; addr_r = {5'd5, 5'd5};
        a_exp("bypass", 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0);
        tick();
        write = 1'b0; read = 1'b0;
        a_rd("after_bypass", 5'd5, 5'd5, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0);

        // Scoreboard
        rsv = 1'b1; addr_rsv = 5'd7; tick(); rsv = 1'b0;
        a_rd("busy_set", 5'd7, 5'd5, 32'd7, 32'h11BB33DD, 1'b1, 1'b0);
        rsv = 1'b1; addr_rsv = 5'd7;
        a_err(1, 1'b1); a_err(2, 1'b0);
        tick(); rsv = 1'b0; tick();
        a_wr(5'd7, 32'h77, 4'hF);
        a_rd("busy_clr", 5'd7, 5'd7, 32'h77, 32'h77, 1'b0, 1'b0);
        rsv = 1'b1; addr_rsv = 5'd7; write = 1'b1; addr_w = 5'd7; data_w = 32'h78; be_w = 4'hF;
        a_err(1, 1'b0);
        tick(); rsv = 1'b0; write = 1'b0;
        a_rd("rsv_wr", 5'd7, 5'd0, 32'h78, 32'd0, 1'b1, 1'b0);
        // Same-cycle busy lookup: BE=0 write clears, reserve sets
        write = 1'b1; addr_w = 5'd7; data_w = 32'hFFFFFFFF; be_w = 4'h0;
        rsv = 1'b1; addr_rsv = 5'd9; read = 1'b1; addr_r = {5'd9, 5'd7};
        a_exp("same_cyc", 32'h78, 32'd9, 1'b0, 1'b1);
        a_err(1, 1'b0);
        tick(); write = 1'b0; rsv = 1'b0; read = 1'b0;
        a_rd("be0_hold", 5'd7, 5'd9, 32'h78, 32'd9, 1'b0, 1'b1);
        rsv = 1'b1; addr_rsv = 5'd0; tick();
        a_err(1, 1'b0);
        tick(); rsv = 1'b0;
        a_rd("zero_busy", 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        a_rd("pre_hold", 5'd5, 5'd7, 32'h11BB33DD, 32'h78, 1'b0, 1'b0);
        addr_r = {5'd0, 5'd0};
        a_wr(5'd5, 32'd0, 4'hF);
        tick();
        chk("hold_data", data_r, {32'h78, 32'h11BB33DD});

        // Variant instance
        b_wr(4'd0,  64'h0123456789ABCDEF, 8'hFF);
        b_wr(4'd5,  64'hFEDCBA9876543210, 8'hFF);
        b_wr(4'd15, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
        b_rd("b_ind", 4'd0, 4'd5, 4'd15,
             64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 3'b000);
        b_rd("b_perm", 4'd15, 4'd0, 4'd5,
             64'h0F0F0F0F0F0F0F0F, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 3'b000);
        b_wr(4'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        b_rd("b_be", 4'd5, 4'd5, 4'd0,
             64'hFEDCBA98FFFFFFFF, 64'hFEDCBA98FFFFFFFF, 64'h0123456789ABCDEF, 3'b000);
        v_rsv = 1'b1; v_addr_rsv = 4'd0; tick(); v_rsv = 1'b0;
        b_rd("b_busy0", 4'd0, 4'd1, 4'd5, 64'h0123456789ABCDEF, 64'd0, 64'hFEDCBA98FFFFFFFF, 3'b001);
        v_rsv = 1'b1; v_addr_rsv = 4'd0;
        begin
            err_exp_t ee;
            ee.cyc = cyc + 1; ee.v = 1'b1; q_err_b.push_back(ee);
            ee.cyc = cyc + 2; ee.v = 1'b0; q_err_b.push_back(ee);
        end
        tick(); v_rsv = 1'b0;

        repeat (4) tick();
        if (q_a.size() != 0 || q_b.size() != 0 || q_err_a.size() != 0 || q_err_b.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover_expectations: got %0d/%0d/%0d/%0d pending expected 0",
                     q_a.size(), q_b.size(), q_err_a.size(), q_err_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
